multicycle_control: RTL

- Multi-cycle control FSM for the MIPS-subset datapath. It sequences FETCH, DECODE, EXEC, MEM and WB, and drives every datapath strobe and mux select.
- It keeps the existing ALU operand/opcode decode (in1Mux/in2Mux/aluOp encodings are unchanged) and adds:
  - jr/j/jal sequencing;
  - a memory ready handshake with timeout;
  - illegal-instruction and bus-error trapping;
  - a retired-instruction counter.
- It sits between the instruction register (OPcode/func inputs) and the datapath.

---
 rtl/ctrl_pkg.sv | 88 ++++++++
 rtl/alu_decode.sv | 58 +++++
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: opcodes, funcs,
// ALU codes, datapath select values, FSM states and trap causes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_SRAV = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  localparam logic [1:0] IN1_RT   = 2'b00;
  localparam logic [1:0] IN1_SEXT = 2'b01;
  localparam logic [1:0] IN1_ZEXT = 2'b10;
  localparam logic       IN2_RS    = 1'b0;
  localparam logic       IN2_SHAMT = 1'b1;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of OPcode/func into ALU operand selects, ALU opcode and
// a legality flag; jumps are legal only when SUPPORT_JUMPS is non-zero.
module alu_decode
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_JUMPS = 1
) (
  input  logic [5:0] OPcode,
  input  logic [5:0] func,
  output logic [1:0] in1Mux,
  output logic       in2Mux,
  output logic [3:0] aluOp,
  output logic       legal
);

  localparam logic JUMPS_OK = (SUPPORT_JUMPS != 0) ? 1'b1 : 1'b0;

  // Variable shifts take their amount from rs, so only the immediate shifts select shamt
  always_comb begin
    in1Mux = IN1_RT;
    in2Mux = IN2_RS;
    aluOp  = ALU_SLL;
    legal  = 1'b0;
    case (OPcode)
      OP_RTYPE: begin
        case (func)
          FN_SLL:  begin aluOp = ALU_SLL;  in2Mux = IN2_SHAMT; legal = 1'b1; end
          FN_SRL:  begin aluOp = ALU_SRL;  in2Mux = IN2_SHAMT; legal = 1'b1; end
          FN_SRA:  begin aluOp = ALU_SRA;  in2Mux = IN2_SHAMT; legal = 1'b1; end
          FN_SLLV: begin aluOp = ALU_SLLV; legal = 1'b1; end
          FN_SRLV: begin aluOp = ALU_SRLV; legal = 1'b1; end
          FN_SRAV: begin aluOp = ALU_SRAV; legal = 1'b1; end
          FN_JR:   begin legal = JUMPS_OK; end
          FN_ADD:  begin aluOp = ALU_ADD;  legal = 1'b1; end
          FN_SUB:  begin aluOp = ALU_SUB;  legal = 1'b1; end
          FN_AND:  begin aluOp = ALU_AND;  legal = 1'b1; end
          FN_OR:   begin aluOp = ALU_OR;   legal = 1'b1; end
          FN_XOR:  begin aluOp = ALU_XOR;  legal = 1'b1; end
          FN_NOR:  begin aluOp = ALU_NOR;  legal = 1'b1; end
          FN_SLT:  begin aluOp = ALU_SLT;  legal = 1'b1; end
          FN_SLTU: begin aluOp = ALU_SLTU; legal = 1'b1; end
          default: begin legal = 1'b0; end
        endcase
      end
      OP_BEQ, OP_BNE:       begin aluOp = ALU_SUB; legal = 1'b1; end
      OP_ADDI, OP_LW, OP_SW: begin in1Mux = IN1_SEXT; aluOp = ALU_ADD; legal = 1'b1; end
      OP_SLTI:  begin in1Mux = IN1_SEXT; aluOp = ALU_SLT;  legal = 1'b1; end
      OP_SLTIU: begin in1Mux = IN1_SEXT; aluOp = ALU_SLTU; legal = 1'b1; end
      OP_ANDI:  begin in1Mux = IN1_ZEXT; aluOp = ALU_AND;  legal = 1'b1; end
      OP_ORI:   begin in1Mux = IN1_ZEXT; aluOp = ALU_OR;   legal = 1'b1; end
      OP_XORI:  begin in1Mux = IN1_ZEXT; aluOp = ALU_XOR;  legal = 1'b1; end
      OP_LUI:   begin in1Mux = IN1_ZEXT; aluOp = ALU_LUI;  legal = 1'b1; end
      OP_J, OP_JAL: begin legal = JUMPS_OK; end
      default:  begin legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handles memory
// handshake timeouts, traps illegal instructions and counts retired instructions.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int TO_W          = 5,
  parameter int CNT_W         = 32,
  parameter int SUPPORT_JUMPS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       OPcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       in1Mux,
  output logic             in2Mux,
  output logic [3:0]       aluOp,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t            state_r, next_state_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic [CNT_W-1:0]  retired_r;
  logic              trap_r;
  logic [1:0]        trap_cause_r;
  logic              retire_s, trap_set_s, waiting_s, to_limit_s;
  logic [1:0]        cause_s;
  logic [1:0]        dec_in1_s;
  logic              dec_in2_s, legal_s;
  logic [3:0]        dec_alu_s;

  wire is_lw_s   = (OPcode == OP_LW);
  wire is_sw_s   = (OPcode == OP_SW);
  wire is_beq_s  = (OPcode == OP_BEQ);
  wire is_bne_s  = (OPcode == OP_BNE);
  wire is_j_s    = (OPcode == OP_J);
  wire is_jal_s  = (OPcode == OP_JAL);
  wire is_jr_s   = is_jr(OPcode, func);
  wire is_rtyp_s = (OPcode == OP_RTYPE);
  wire ends_in_exec_s = is_beq_s | is_bne_s | is_j_s | is_jal_s | is_jr_s;

  alu_decode #(.SUPPORT_JUMPS(SUPPORT_JUMPS)) u_alu_decode (
    .OPcode (OPcode),
    .func   (func),
    .in1Mux (dec_in1_s),
    .in2Mux (dec_in2_s),
    .aluOp  (dec_alu_s),
    .legal  (legal_s)
  );

  assign waiting_s  = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
  assign to_limit_s = (to_cnt_r == TO_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_FETCH;
    else          state_r <= next_state_s;
  end

  // Next-state, retire and trap-entry decisions; mem_ready beats the timeout
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    trap_set_s   = 1'b0;
    cause_s      = CAUSE_NONE;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) next_state_s = ST_DECODE;
        else if (to_limit_s) begin
          next_state_s = ST_TRAP; trap_set_s = 1'b1; cause_s = CAUSE_BUS;
        end else next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (legal_s) next_state_s = ST_EXEC;
        else begin
          next_state_s = ST_TRAP; trap_set_s = 1'b1; cause_s = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (ends_in_exec_s) begin
          next_state_s = ST_FETCH; retire_s = 1'b1;
        end else if (is_lw_s || is_sw_s) next_state_s = ST_MEM;
        else next_state_s = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (is_sw_s) begin
            next_state_s = ST_FETCH; retire_s = 1'b1;
          end else next_state_s = ST_WB;
        end else if (to_limit_s) begin
          next_state_s = ST_TRAP; trap_set_s = 1'b1; cause_s = CAUSE_BUS;
        end else next_state_s = ST_MEM;
      end
      ST_WB:   begin next_state_s = ST_FETCH; retire_s = 1'b1; end
      ST_TRAP: begin next_state_s = ST_TRAP; end
      default: begin next_state_s = ST_FETCH; end
    endcase
  end

  // Wait counter restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       to_cnt_r <= {TO_W{1'b0}};
    else if (next_state_s != state_r)   to_cnt_r <= {TO_W{1'b0}};
    else if (waiting_s)                 to_cnt_r <= to_cnt_r + TO_W'(1);
    else                                to_cnt_r <= to_cnt_r;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      retired_r <= {CNT_W{1'b0}};
    else if (retire_s) retired_r <= retired_r + CNT_W'(1);
    else               retired_r <= retired_r;
  end

  // Trap flag and cause are sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_r       <= 1'b0;
      trap_cause_r <= CAUSE_NONE;
    end else if (trap_set_s) begin
      trap_r       <= 1'b1;
      trap_cause_r <= cause_s;
    end else begin
      trap_r       <= trap_r;
      trap_cause_r <= trap_cause_r;
    end
  end

  // Datapath strobes; forced quiet while reset is asserted
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    in1Mux     = IN1_RT;
    in2Mux     = IN2_RS;
    aluOp      = ALU_SLL;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALU;
    if (reset_n) begin
      case (state_r)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1; pc_write = 1'b1; pc_src = PC_PLUS4;
          end else ir_write = 1'b0;
        end
        ST_EXEC: begin
          in1Mux = dec_in1_s;
          in2Mux = dec_in2_s;
          aluOp  = dec_alu_s;
          if ((is_beq_s && zero) || (is_bne_s && !zero)) begin
            pc_write = 1'b1; pc_src = PC_BRANCH;
          end else if (is_j_s || is_jal_s) begin
            pc_write = 1'b1; pc_src = PC_JUMP;
            reg_write  = is_jal_s;
            reg_dst    = is_jal_s ? DST_RA : DST_RT;
            mem_to_reg = is_jal_s ? WB_PC : WB_ALU;
          end else if (is_jr_s) begin
            pc_write = 1'b1; pc_src = PC_RS;
          end else pc_write = 1'b0;
        end
        ST_MEM: begin
          iord      = 1'b1;
          mem_read  = is_lw_s;
          mem_write = is_sw_s;
        end
        ST_WB: begin
          reg_write = 1'b1;
          if (is_lw_s) begin
            reg_dst = DST_RT; mem_to_reg = WB_MEM;
          end else if (is_rtyp_s) begin
            reg_dst = DST_RD; mem_to_reg = WB_ALU;
          end else begin
            reg_dst = DST_RT; mem_to_reg = WB_ALU;
          end
        end
        default: begin mem_read = 1'b0; end
      endcase
    end else begin
      mem_read = 1'b0;
    end
  end

  assign trap       = trap_r;
  assign trap_cause = trap_cause_r;
  assign retired    = retired_r;

endmodule
